// File: rtl/key_cmd_queue.sv
// Encodes debounced key press pulses into key indices and queues them in a
// show-ahead FIFO behind a valid/ready handshake. Pending presses are pushed lowest index first.
module key_cmd_queue #(
    parameter int NKEYS  = 5,
    parameter int CODE_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic [NKEYS-1:0]           key_pulse,
    input  logic                       cmd_ready,
    input  logic                       ovf_clr,
    output logic                       cmd_valid,
    output logic [CODE_W-1:0]          cmd_code,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = PW + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [NKEYS-1:0]  pend_q, pend_d;
    logic [CODE_W-1:0] mem_q [DEPTH];
    logic [CODE_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;

    logic              empty, pop, can_push, push, merge;
    logic [CODE_W-1:0] sel_idx;
    logic [NKEYS-1:0]  sel_hot, push_hot;

    assign empty    = (count_q == '0);
    assign pop      = !empty && cmd_ready;
    // A pop in the same cycle frees the slot the push is about to fill.
    assign can_push = (count_q < FULL) || pop;
    assign push     = can_push && (pend_q != '0);

    always_comb begin
        sel_idx = '0;
        sel_hot = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel_idx    = CODE_W'(i);
                sel_hot    = '0;
                sel_hot[i] = 1'b1;
            end
        end
    end

    assign push_hot = push ? sel_hot : '0;
    // A pulse on the bit being pushed this cycle counts as a fresh press, not a merge.
    assign merge    = |(key_pulse & pend_q & ~push_hot);

    always_comb begin
        pend_d  = (pend_q & ~push_hot) | key_pulse;
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        if (push) begin
            mem_d[wptr_q] = sel_idx;
            wptr_d        = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (merge) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pend_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            pend_q  <= pend_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            mem_q   <= mem_d;
        end
    end

    assign cmd_valid = !empty;
    assign cmd_code  = empty ? '0 : mem_q[rptr_q];
    assign count     = count_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_key_cmd_queue.sv
// Bench for key_cmd_queue: directed scenarios plus randomized traffic, all
// checked against a queue-based model of pending presses and the FIFO.
module tb_key_cmd_queue;

    localparam int NKEYS  = 5;
    localparam int CODE_W = 3;
    localparam int DEPTH  = 8;

    logic                  clk = 1'b0;
    logic                  clr_n;
    logic [NKEYS-1:0]      key_pulse;
    logic                  cmd_ready;
    logic                  ovf_clr;
    logic                  cmd_valid;
    logic [CODE_W-1:0]     cmd_code;
    logic [$clog2(DEPTH):0] count;
    logic                  ovf;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: pending set, FIFO contents as a queue, sticky flag.
    int              m_q[$];
    bit [NKEYS-1:0]  m_pend;
    bit              m_ovf;

    key_cmd_queue #(.NKEYS(NKEYS), .CODE_W(CODE_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .key_pulse (key_pulse),
        .cmd_ready (cmd_ready),
        .ovf_clr   (ovf_clr),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .count     (count),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("valid", int'(cmd_valid), int'(m_q.size() != 0));
        chk("code",  int'(cmd_code),  (m_q.size() != 0) ? m_q[0] : 0);
        chk("count", int'(count),     m_q.size());
        chk("ovf",   int'(ovf),       int'(m_ovf));
    endtask

    task automatic model_edge(input bit [NKEYS-1:0] kp, input bit rdy, input bit oc);
        bit pop, can, pushed, merged;
        int idx;
        pop    = (m_q.size() != 0) && rdy;
        can    = (m_q.size() < DEPTH) || pop;
        pushed = 1'b0;
        idx    = -1;
        if (can) begin
            for (int i = 0; i < NKEYS; i++) begin
                if (m_pend[i] && idx < 0) idx = i;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (idx >= 0) begin
            m_q.push_back(idx);
            m_pend[idx] = 1'b0;
            pushed = 1'b1;
        end
        merged = 1'b0;
        for (int i = 0; i < NKEYS; i++) begin
            if (kp[i]) begin
                if (m_pend[i]) merged = 1'b1;
                else if (!(pushed && idx == i)) m_pend[i] = 1'b1;
                else m_pend[i] = 1'b1;
            end
        end
        if (merged) m_ovf = 1'b1;
        else if (oc) m_ovf = 1'b0;
    endtask

    task automatic step(input bit [NKEYS-1:0] kp, input bit rdy, input bit oc);
        @(negedge clk);
        key_pulse = kp;
        cmd_ready = rdy;
        ovf_clr   = oc;
        #1;
        check_outputs();
        model_edge(kp, rdy, oc);
        @(posedge clk);
    endtask

    // Reset asserted between edges: outputs must clear before any clock edge.
    task automatic async_reset();
        @(negedge clk);
        key_pulse = '0;
        cmd_ready = 1'b0;
        ovf_clr   = 1'b0;
        #2 clr_n = 1'b0;
        #1;
        m_q.delete();
        m_pend = '0;
        m_ovf  = 1'b0;
        chk("rst_valid", int'(cmd_valid), 0);
        chk("rst_code",  int'(cmd_code),  0);
        chk("rst_count", int'(count),     0);
        chk("rst_ovf",   int'(ovf),       0);
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step('0, rdy, 1'b0);
    endtask

    initial begin
        int keys [8] = '{0, 1, 2, 3, 4, 0, 1, 2};
        int pct;
        key_pulse = '0;
        cmd_ready = 1'b0;
        ovf_clr   = 1'b0;
        clr_n     = 1'b0;
        m_pend    = '0;
        m_ovf     = 1'b0;
        #12;
        check_outputs();
        clr_n = 1'b1;

        // Single press of key 2, then one pop.
        step(5'b00100, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        #1;
        chk("single_code", int'(cmd_code), 2);
        chk("single_cnt",  int'(count), 1);
        step('0, 1'b1, 1'b0);
        idle(2, 1'b0);

        // Simultaneous presses drain in index order.
        step(5'b11001, 1'b0, 1'b0);
        idle(4, 1'b0);
        #1;
        chk("simul_cnt", int'(count), 3);
        idle(4, 1'b1);

        // Fill, hold an extra press pending, then pop one.
        foreach (keys[k]) begin
            step(NKEYS'(1 << keys[k]), 1'b0, 1'b0);
            idle(2, 1'b0);
        end
        #1;
        chk("full_cnt", int'(count), 8);
        step(5'b01000, 1'b0, 1'b0);
        idle(2, 1'b0);
        step('0, 1'b1, 1'b0);
        #1;
        chk("refill_cnt", int'(count), 8);
        chk("refill_head", int'(cmd_code), 1);

        // Merge while full sets ovf; clear; merge coinciding with clear wins.
        step(5'b00010, 1'b0, 1'b0);
        step(5'b00010, 1'b0, 1'b0);
        #1;
        chk("merge_ovf", int'(ovf), 1);
        step('0, 1'b0, 1'b1);
        step(5'b00010, 1'b0, 1'b1);
        #1;
        chk("merge_set_wins", int'(ovf), 1);
        step('0, 1'b0, 1'b1);

        // Full with push+pop every cycle.
        for (int i = 0; i < 20; i++) step(NKEYS'(1 << (i % NKEYS)), 1'b1, 1'b0);
        idle(12, 1'b1);

        // Reset with queued and pending presses.
        for (int i = 0; i < 5; i++) step(NKEYS'(1 << i), 1'b0, 1'b0);
        step(5'b00001, 1'b0, 1'b0);
        async_reset();
        idle(3, 1'b0);

        // Randomized traffic with varying consumer pressure.
        for (int r = 0; r < 1500; r++) begin
            bit [NKEYS-1:0] kp;
            pct = (r / 150) % 2 ? 80 : 25;
            kp  = NKEYS'($urandom & $urandom & $urandom);
            step(kp, $urandom_range(0, 99) < pct, $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0) async_reset();
        end
        idle(20, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/key_cmd_queue.md
# key_cmd_queue

Downstream consumer of the per-key debounce/edge stages. Collects one-cycle press pulses from up to NKEYS debounced keys and encodes each press as a key index. Queues presses in arrival order in a small show-ahead FIFO so that simultaneous or rapid presses are not lost. Presents commands to game/control logic through a valid/ready handshake.

## Interface
- NKEYS, 5: number of key pulse inputs; must satisfy NKEYS ≤ 2^CODE_W.
- CODE_W, 3: width of the encoded key index.
- DEPTH, 8: FIFO depth; must be a power of 2, ≥ 2.
- clk  in  1  system clock; all state updates on the rising edge.
- clr_n  in  1  reset, asynchronous, active-low.
- key_pulse  in  NKEYS  one-cycle press pulses, one bit per key, from the debounce stages.
- cmd_ready  in  1  consumer accepts the head entry this cycle.
- ovf_clr  in  1  synchronous clear of ovf.
- cmd_valid  out  1  FIFO non-empty.
- cmd_code  out  CODE_W  key index at the FIFO head; 0 when empty.
- count  out  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- ovf  out  1  sticky flag: a press was merged or lost.

## Operation
- Pending register pend[NKEYS-1:0]. A key_pulse[i] high at an edge sets pend[i].
- Push selection: each cycle, if pend ≠ 0 and the FIFO can accept, the lowest-index set bit i is selected. Code i is written at the tail, and pend[i] clears at that edge.
- FIFO can accept when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
- Pulse on bit i in the same cycle that pend[i] is pushed: pend[i] stays set. This is a new press, and ovf is not set.
- Pulse on bit i while pend[i] is set and not being pushed that cycle: the press merges into the pending one and ovf is set.
- Pop: cmd_valid && cmd_ready removes the head. cmd_ready while empty has no effect.
- Push and pop in the same cycle: count is unchanged, and order is preserved in all cases including full and one-entry.
- The FIFO is show-ahead: cmd_code shows the head combinationally from storage while cmd_valid=1. It is forced to 0 when empty.
- Read and write pointers are clog2(DEPTH) bits wide and wrap modulo DEPTH. count is a separate register, incremented or decremented per push/pop.
- ovf clears only when ovf_clr is high. If set and clear conditions coincide, set wins.
- Keys ≥ NKEYS do not exist, so codes never exceed NKEYS-1.

## Timing
- Reset (clr_n low, asynchronous): pend=0, pointers=0, count=0, cmd_valid=0, cmd_code=0, ovf=0. These take effect immediately, without waiting for a clock edge.
- Reset released mid-operation: all queued and pending presses are discarded.
- Latency: with the FIFO empty and no other pending bits, a key_pulse sampled at edge t sets pend at edge t. The push happens at edge t+1, so cmd_valid and cmd_code are valid after edge t+1.
- Pulses arriving at the same edge are pushed in ascending index order, one per cycle, on consecutive cycles.
- Throughput: at most one push and one pop per cycle.
- While the FIFO is full with no pop, pend holds its presses. They drain in index order once space frees.
- count and cmd_valid are registered-state derived and update only on clock edges, except for reset.

## Test plan
- Single press: key_pulse=5'b00100 for one cycle at edge 10, cmd_ready=0 → cmd_valid=1 and cmd_code=2 after edge 11, count=1. Then cmd_ready=1 for one cycle → cmd_valid=0, count=0, cmd_code=0.
- Simultaneous presses: key_pulse=5'b11001 at one edge, cmd_ready=0 → entries pushed on three consecutive edges. Draining yields codes 0, 3, 4; count peaks at 3; ovf=0.
- Full/backpressure: DEPTH=8 with cmd_ready=0; press keys 0,1,2,3,4,0,1,2 (one per 3 cycles) → count=8. A further press of key 3 stays pending with count=8. One pop → key 3 is pushed the same cycle, count returns to 8, and the drain order is 1,2,3,4,0,1,2,3. ovf=0.
- Merge/overflow: FIFO full, key 1 pressed twice without any pop → ovf=1 and only one code 1 is queued after a pop. Pulse ovf_clr → ovf=0. Simultaneous re-press and ovf_clr → ovf=1.
- Push+pop when full: count=8, cmd_ready=1 held while keys press every cycle → count stays 8 and the output sequence matches input order exactly.
- Asynchronous reset: assert clr_n=0 between clock edges with count=5 and pend≠0 → count, cmd_valid, cmd_code and ovf go to 0 immediately. After release, no stale code appears.
